// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack port, stalls
// upstream while a transfer is outstanding, and registers results for write-back.
module mem_access #(
    parameter int         XLEN     = 32,
    parameter int         EX_W     = 4,
    parameter int         TIMEOUT  = 255,
    parameter logic [4:0] OP_LOAD  = 5'b00000,
    parameter logic [4:0] OP_STORE = 5'b01000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipeline_in_valid,
    input  logic [4:0]      opcode_in,
    input  logic [2:0]      funct_in,
    input  logic            nop_instr_in,
    input  logic [EX_W-1:0] exception_in,
    input  logic            exception_in_valid,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush_in,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_err,
    output logic            pipeline_out_valid,
    output logic [4:0]      opcode_out,
    output logic [4:0]      rd_addr_out,
    output logic [XLEN-1:0] wb_data,
    output logic            nop_instr_out,
    output logic [EX_W-1:0] exception_out,
    output logic            exception_out_valid
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]   cnt;
    logic            cap_store, cap_byte, cap_half, cap_signed, cap_discard;
    logic [1:0]      cap_lo;
    logic [XLEN-1:0] cap_result;
    logic [4:0]      cap_rd, cap_opcode;

    logic            is_load, is_store, memop, byte_op, half_op, misaligned, start;
    logic            finish, fault, tmo;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata, load_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    // Undefined funct values fall through to word size.
    always_comb begin
        is_load    = (opcode_in == OP_LOAD);
        is_store   = (opcode_in == OP_STORE);
        memop      = pipeline_in_valid & ~exception_in_valid & ~nop_instr_in & (is_load | is_store);
        byte_op    = is_store ? (funct_in == 3'b000) : (funct_in[1:0] == 2'b00);
        half_op    = is_store ? (funct_in == 3'b001) : (funct_in[1:0] == 2'b01);
        misaligned = half_op ? addr_in[0] : (~byte_op & (addr_in[1:0] != 2'b00));
        start      = (state == IDLE) & memop & ~misaligned & ~flush_in;
        stall_out  = reset & ((state == IDLE) ? start : ~dmem_ack);
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = result_in;
        if (!is_store) begin
            st_wdata = '0;
        end else if (byte_op) begin
            st_be    = 4'b0001 << addr_in[1:0];
            st_wdata = {4{result_in[7:0]}};
        end else if (half_op) begin
            st_be    = addr_in[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{result_in[15:0]}};
        end
    end

    always_comb begin
        case (cap_lo)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = cap_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (cap_byte)
            load_data = {{(XLEN-8){cap_signed & ld_byte[7]}}, ld_byte};
        else if (cap_half)
            load_data = {{(XLEN-16){cap_signed & ld_half[15]}}, ld_half};
        else
            load_data = dmem_rdata;
    end

    always_comb begin
        state_nxt = state;
        tmo       = (cnt == CW'(TIMEOUT - 1));
        finish    = 1'b0;
        fault     = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = BUSY;
            BUSY: begin
                finish = dmem_ack | tmo;
                fault  = dmem_ack ? dmem_err : tmo;
                if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt                 <= '0;
            cap_store           <= 1'b0;
            cap_byte            <= 1'b0;
            cap_half            <= 1'b0;
            cap_signed          <= 1'b0;
            cap_discard         <= 1'b0;
            cap_lo              <= 2'b00;
            cap_result          <= '0;
            cap_rd              <= '0;
            cap_opcode          <= '0;
            dmem_req            <= 1'b0;
            dmem_we             <= 1'b0;
            dmem_addr           <= '0;
            dmem_be             <= '0;
            dmem_wdata          <= '0;
            pipeline_out_valid  <= 1'b0;
            opcode_out          <= '0;
            rd_addr_out         <= '0;
            wb_data             <= '0;
            nop_instr_out       <= 1'b0;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
        end else begin
            pipeline_out_valid <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    cnt         <= '0;
                    cap_store   <= is_store;
                    cap_byte    <= byte_op;
                    cap_half    <= half_op;
                    cap_signed  <= ~funct_in[2];
                    cap_discard <= 1'b0;
                    cap_lo      <= addr_in[1:0];
                    cap_result  <= result_in;
                    cap_rd      <= rd_addr_in;
                    cap_opcode  <= opcode_in;
                    dmem_req    <= 1'b1;
                    dmem_we     <= is_store;
                    dmem_addr   <= {addr_in[XLEN-1:2], 2'b00};
                    dmem_be     <= st_be;
                    dmem_wdata  <= st_wdata;
                end else if (pipeline_in_valid && !flush_in) begin
                    pipeline_out_valid <= 1'b1;
                    opcode_out         <= opcode_in;
                    rd_addr_out        <= rd_addr_in;
                    nop_instr_out      <= nop_instr_in;
                    wb_data            <= result_in;
                    if (memop) begin
                        exception_out       <= is_store ? EX_W'(6) : EX_W'(4);
                        exception_out_valid <= 1'b1;
                    end else begin
                        exception_out       <= exception_in;
                        exception_out_valid <= exception_in_valid;
                    end
                end
            end else begin
                if (flush_in) cap_discard <= 1'b1;
                if (finish) begin
                    dmem_req <= 1'b0;
                    // A flushed transfer still runs to completion but leaves outputs untouched.
                    if (!cap_discard && !flush_in) begin
                        pipeline_out_valid  <= 1'b1;
                        opcode_out          <= cap_opcode;
                        rd_addr_out         <= cap_rd;
                        nop_instr_out       <= 1'b0;
                        wb_data             <= (!cap_store && !fault) ? load_data : cap_result;
                        exception_out       <= !fault ? '0 : (cap_store ? EX_W'(7) : EX_W'(5));
                        exception_out_valid <= fault;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
